// File: rtl/div_rr_scheduler_if.sv
// Request/response bundle between the requesters, the shared divider
// scheduler and the result consumer.
interface div_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_quotient;
  logic [W-1:0]      rsp_remainder;
  logic              rsp_dbz;

  // Requester/consumer side: issues operands, accepts results
  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );

  // Scheduler side: grants requests, presents results
  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz
  );
endinterface

// File: rtl/div_rr_scheduler.sv
// Round-robin scheduler sharing one iterative restoring unsigned divider
// among NREQ requesters. One quotient bit is produced per enabled cycle;
// a zero divisor short-circuits to an all-ones result with the dbz flag.
// W must be at least 2.
module div_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  output logic                 busy,
  div_rr_scheduler_if.slave    bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rrPtr_q;
  logic [IDW-1:0]  id_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    dvs_q;
  logic            rspValid_q;
  logic [IDW-1:0]  rspId_q;
  logic [W-1:0]    rspQuo_q;
  logic [W-1:0]    rspRem_q;
  logic            rspDbz_q;

  logic            found_d;
  logic [IDW-1:0]  winner_d;
  logic [IDW-1:0]  idx_d;
  logic [IDW-1:0]  nextPtr_d;
  logic [W-1:0]    winDvd_d;
  logic [W-1:0]    winDvs_d;
  logic [NREQ-1:0] ready_d;
  logic [W:0]      shifted_d;
  logic [W:0]      diff_d;
  logic            qBit_d;
  logic [W-1:0]    remStep_d;
  logic [W-1:0]    quoStep_d;

  // Find the first pending requester at or after the pointer, wrapping around,
  // and mux out its operands
  always_comb begin
    found_d  = 1'b0;
    winner_d = '0;
    idx_d    = '0;
    winDvd_d = '0;
    winDvs_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_d = IDW'((int'(rrPtr_q) + k) % NREQ);
      if (!found_d && bus.req_valid[idx_d]) begin
        found_d  = 1'b1;
        winner_d = idx_d;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (winner_d == IDW'(i)) begin
        winDvd_d = bus.req_dividend[i*W +: W];
        winDvs_d = bus.req_divisor[i*W +: W];
      end
    end
  end

  // Grant is offered only while idle and enabled, one-hot on the winner
  always_comb begin
    ready_d = '0;
    if (state_q == IDLE && ena && found_d) begin
      ready_d[winner_d] = 1'b1;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    shifted_d = {rem_q, quo_q[W-1]};
    diff_d    = shifted_d - {1'b0, dvs_q};
    qBit_d    = (shifted_d >= {1'b0, dvs_q});
    remStep_d = qBit_d ? diff_d[W-1:0] : shifted_d[W-1:0];
    quoStep_d = {quo_q[W-2:0], qBit_d};
  end

  assign nextPtr_d = (winner_d == IDW'(NREQ-1)) ? '0 : winner_d + 1'b1;

  // Scheduler FSM; everything holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspQuo_q   <= '0;
      rspRem_q   <= '0;
      rspDbz_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            id_q    <= winner_d;
            rrPtr_q <= nextPtr_d;
            quo_q   <= winDvd_d;
            dvs_q   <= winDvs_d;
            rem_q   <= '0;
            if (winDvs_d == '0) begin
              rspId_q    <= winner_d;
              rspQuo_q   <= '1;
              rspRem_q   <= '1;
              rspDbz_q   <= 1'b1;
              rspValid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q   <= CW'(W-1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= remStep_d;
          quo_q <= quoStep_d;
          if (cnt_q == '0) begin
            rspId_q    <= id_q;
            rspQuo_q   <= quoStep_d;
            rspRem_q   <= remStep_d;
            rspDbz_q   <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready_d;
  assign bus.rsp_valid     = rspValid_q;
  assign bus.rsp_id        = rspId_q;
  assign bus.rsp_quotient  = rspQuo_q;
  assign bus.rsp_remainder = rspRem_q;
  assign bus.rsp_dbz       = rspDbz_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Scoreboard bench for the round-robin divider scheduler: stimulus pushes the
// expected result of every grant, a monitor pops and compares on each handshake.
module tb_div_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  typedef struct {
    int id;
    int q;
    int r;
    int dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic busy;

  exp_t sb[$];
  int   grantOrder[$];
  int   opDvd[NREQ];
  int   opDvs[NREQ];
  int   total = 0;
  int   bad = 0;
  int   lat;

  div_rr_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  div_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .busy (busy),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout/unexpected event, expected normal progress", name);
  endtask

  function automatic exp_t model(input int id, input int dvd, input int dvs);
    exp_t e;
    e.id = id;
    if (dvs == 0) begin
      e.q = (1 << W) - 1;
      e.r = (1 << W) - 1;
      e.dbz = 1;
    end else begin
      e.q = dvd / dvs;
      e.r = dvd % dvs;
      e.dbz = 0;
    end
    return e;
  endfunction

  task automatic setReq(input int id, input int dvd, input int dvs);
    opDvd[id] = dvd;
    opDvs[id] = dvs;
    bus.req_dividend[id*W +: W] = W'(dvd);
    bus.req_divisor[id*W +: W]  = W'(dvs);
    bus.req_valid[id] = 1'b1;
  endtask

  // Wait for n grants in the order queued in grantOrder; push expectations
  task automatic applyStimulus(input int n, input bit dropOnGrant);
    int expId;
    int waitCnt;
    for (int g = 0; g < n; g++) begin
      expId = grantOrder.pop_front();
      waitCnt = 0;
      do begin
        @(negedge clk);
        waitCnt++;
      end while (bus.req_ready == '0 && waitCnt < 200);
      if (bus.req_ready == '0) begin
        failNow("grant wait");
        return;
      end
      checkOutput("grant one-hot", int'(bus.req_ready), 1 << expId);
      sb.push_back(model(expId, opDvd[expId], opDvs[expId]));
      @(posedge clk);
      #1;
      if (dropOnGrant) bus.req_valid[expId] = 1'b0;
    end
    if (!dropOnGrant) bus.req_valid = '0;
  endtask

  // Count edges from the accept edge until rsp_valid; optionally freeze mid-way
  task automatic waitRsp(input int freezeAt, input int freezeLen, output int latOut);
    latOut = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
      if (latOut == freezeAt) begin
        ena = 1'b0;
        repeat (freezeLen) begin
          @(posedge clk);
          latOut++;
        end
        #1;
        ena = 1'b1;
        continue;
      end
      @(posedge clk);
      #1;
      latOut++;
    end
    latOut = -1;
  endtask

  // Monitor: every accepted response is checked against the scoreboard head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ena && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        failNow("unexpected response");
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_id", int'(bus.rsp_id), e.id);
        checkOutput("rsp_quotient", int'(bus.rsp_quotient), e.q);
        checkOutput("rsp_remainder", int'(bus.rsp_remainder), e.r);
        checkOutput("rsp_dbz", int'(bus.rsp_dbz), e.dbz);
      end
    end
  end

  // Hard stop if something wedges beyond every local bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("reset rsp_id", int'(bus.rsp_id), 0);
    checkOutput("reset rsp_quotient", int'(bus.rsp_quotient), 0);
    checkOutput("reset rsp_remainder", int'(bus.rsp_remainder), 0);
    checkOutput("reset rsp_dbz", int'(bus.rsp_dbz), 0);
    checkOutput("reset busy", int'(busy), 0);

    rst_n = 1'b1;
    ena = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single request 13/4");
    setReq(0, 13, 4);
    grantOrder.push_back(0);
    applyStimulus(1, 1'b1);
    waitRsp(-1, 0, lat);
    checkOutput("latency normal", lat, W + 1);
    @(posedge clk);
    #1;
    checkOutput("busy after handshake", int'(busy), 0);

    $display("[TB] divide by zero 9/0");
    setReq(2, 9, 0);
    grantOrder.push_back(2);
    applyStimulus(1, 1'b1);
    waitRsp(-1, 0, lat);
    checkOutput("latency dbz", lat, 1);
    @(posedge clk);
    #1;
    checkOutput("busy after dbz", int'(busy), 0);

    $display("[TB] reset mid-calc");
    setReq(1, 13, 2);
    grantOrder.push_back(1);
    applyStimulus(1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midreset rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("midreset rsp_id", int'(bus.rsp_id), 0);
    checkOutput("midreset rsp_quotient", int'(bus.rsp_quotient), 0);
    checkOutput("midreset rsp_remainder", int'(bus.rsp_remainder), 0);
    checkOutput("midreset rsp_dbz", int'(bus.rsp_dbz), 0);
    checkOutput("midreset busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] round-robin fairness");
    setReq(0, 7, 3);
    setReq(1, 15, 15);
    setReq(2, 5, 0);
    setReq(3, 0, 7);
    grantOrder.push_back(0);
    grantOrder.push_back(1);
    grantOrder.push_back(2);
    grantOrder.push_back(3);
    grantOrder.push_back(0);
    applyStimulus(5, 1'b0);

    $display("[TB] enable freeze 15/2");
    setReq(1, 15, 2);
    grantOrder.push_back(1);
    applyStimulus(1, 1'b1);
    waitRsp(2, 3, lat);
    checkOutput("latency frozen", lat, W + 1 + 3);
    @(posedge clk);
    #1;

    $display("[TB] backpressure 14/3");
    bus.rsp_ready = 1'b0;
    setReq(1, 14, 3);
    grantOrder.push_back(1);
    applyStimulus(1, 1'b1);
    waitRsp(-1, 0, lat);
    checkOutput("latency backpressure", lat, W + 1);
    setReq(3, 6, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("hold rsp_valid", int'(bus.rsp_valid), 1);
      checkOutput("hold rsp_id", int'(bus.rsp_id), 1);
      checkOutput("hold rsp_quotient", int'(bus.rsp_quotient), 4);
      checkOutput("hold rsp_remainder", int'(bus.rsp_remainder), 2);
      checkOutput("hold busy", int'(busy), 1);
      checkOutput("hold req_ready", int'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    ena = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready ignored while disabled", int'(bus.rsp_valid), 1);
    @(posedge clk);
    #1;
    ena = 1'b1;
    grantOrder.push_back(3);
    applyStimulus(1, 1'b1);
    waitRsp(-1, 0, lat);
    checkOutput("latency after release", lat, W + 1);
    @(posedge clk);
    #1;

    $display("[TB] exhaustive sweep");
    for (int dvd = 0; dvd < 16; dvd++) begin
      for (int dvs = 0; dvs < 16; dvs++) begin
        int id;
        id = (dvd * 16 + dvs) % NREQ;
        setReq(id, dvd, dvs);
        grantOrder.push_back(id);
        applyStimulus(1, 1'b1);
        waitRsp(-1, 0, lat);
        checkOutput("sweep latency", lat, (dvs == 0) ? 1 : W + 1);
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
